lsu_mem_if: RTL and testbench
=============================

Name: lsu_mem_if

Overview:
- Load/store unit between the execute stage and the byte-addressed data memory.
- Accepts one load/store request per handshake and decodes RV32I funct3.
- Drives the data memory's address, write-data, byte-enable and read/write strobes.
- Returns sign- or zero-extended load data, or a store completion, on a valid/ready response channel.

Parameters:
- READ_LAT, 1, cycles data_read_valid is held before data_read is sampled (1..15)
- ADDR_W, 32, width of data_addr and req_addr

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_is_store  input  1  1 = store, 0 = load
- req_funct3  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data, low bits significant
- req_rd  input  5  load destination register tag
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  32  extended load data; 0 for stores
- resp_rd  output  5  tag echoed from request
- resp_misaligned  output  1  access faulted, no memory access made
- data_addr  output  ADDR_W  memory address
- data_write  output  32  memory write data
- data_write_byte  output  4  byte enables; bit k = word offset k
- data_read_valid  output  1  memory read strobe
- data_write_valid  output  1  memory write strobe
- data_read  input  32  memory read data; byte at word offset k on bits [31-8k:24-8k]

Behaviour:
- Reset (reset=0, async):
  - FSM returns to IDLE.
  - req_ready=1; every other output is 0.
  - Any in-flight access is abandoned and no response is issued.
- FSM states: IDLE, MEM, RESP.
- IDLE:
  - req_ready=1; all memory strobes 0.
  - A handshake (req_valid & req_ready) latches addr, wdata, funct3, is_store and rd.
  - Misaligned requests go to RESP; all others go to MEM.
  - Misaligned means: h/hu with addr[0]=1, or w with addr[1:0]≠00.
  - Unsupported funct3 (011, 110, 111) is treated as misaligned.
- MEM:
  - data_addr = latched addr, full byte address.
  - Store: data_write_valid=1 for exactly 1 cycle, then RESP.
    - data_write = store byte replicated ×4 for b, halfword replicated ×2 for h, wdata for w.
    - data_write_byte = 0001<<addr[1:0] for b, 0011<<addr[1:0] for h, 1111 for w.
  - Load: data_read_valid=1 and data_write_byte=0 for READ_LAT cycles, counted by a down-counter.
    - data_read is registered in the last MEM cycle, then RESP.
- Load assembly:
  - Byte k = data_read[31-8k:24-8k].
  - Little-endian value: b/bu uses byte addr[1:0]; h/hu uses bytes off, off+1; w is {b3,b2,b1,b0}.
  - b and h sign-extend; bu and hu zero-extend.
- RESP:
  - resp_valid=1; resp_rdata, resp_rd and resp_misaligned are held stable until resp_ready.
  - The resp_valid & resp_ready cycle returns the FSM to IDLE.
  - req_ready rises the next cycle; there is no same-cycle re-accept.
- Minimum latency:
  - Store: accept to resp_valid is 2 cycles.
  - Load: 1+READ_LAT cycles.
  - Fault: 1 cycle.
- Request inputs are ignored outside IDLE.
- A misaligned access never asserts data_read_valid or data_write_valid.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misalignment detection and resp_misaligned behave as above.
- Undefined:
  - Addresses are forced to natural alignment: addr[0] cleared for h/hu; addr[1:0] cleared for w.
  - Unsupported funct3 is treated as w.
  - Every request goes to MEM.
  - resp_misaligned is tied to 0.

Test Plan:
- sw wdata=0x12345678 addr=0x8 -> one cycle of data_write_valid, data_addr=0x8, data_write_byte=1111, data_write=0x12345678; resp_valid, resp_rdata=0.
- sb wdata=0x000000AB addr=0x5 -> data_write_byte=0010, data_write=0xABABABAB; sh wdata=0xBEEF addr=0x6 -> byte enables 1100, data_write=0xBEEFBEEF.
- data_read=0x11803344, READ_LAT=1, rd=7:
  - lb addr=1 -> resp_rdata=0xFFFFFF80; lbu addr=1 -> 0x00000080.
  - lh addr=2 -> 0x00004433; lw addr=0 -> 0x44338011.
  - resp_rd=7 in each case.
- lw addr=0x6 (trap enabled) -> no memory strobes, resp_valid one cycle after accept with resp_misaligned=1; with macro undefined -> data_addr=0x4.
- Hold resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0, new req_valid ignored; resp_ready=1 -> IDLE, req_ready=1 next cycle.
- READ_LAT=3 load with reset driven low in 2nd MEM cycle -> all outputs 0 immediately, req_ready=1, no response after reset release.

Source files
------------

// File: rtl/lsu_mem_if.sv
// Load/store unit bridging execute-stage requests to a byte-addressed data memory.
// Optional macro LSU_MISALIGN_TRAP_EN: fault misaligned/unsupported accesses instead of aligning.
module lsu_mem_if #(
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_misaligned,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_write,
  output logic [3:0]        data_write_byte,
  output logic              data_read_valid,
  output logic              data_write_valid,
  input  logic [31:0]       data_read
);

  typedef enum logic [1:0] {StIdle, StMem, StResp} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic              store_q;
  logic [4:0]        rd_q;
  logic [3:0]        cnt_q;

  logic              req_ready_q, resp_valid_q, resp_mis_q, rvalid_q, wvalid_q;
  logic [31:0]       resp_rdata_q, data_write_q;
  logic [4:0]        resp_rd_q;
  logic [ADDR_W-1:0] data_addr_q;
  logic [3:0]        data_be_q;

  logic [ADDR_W-1:0] addr_acc;
  logic [2:0]        f3_acc;
  logic              mis_acc, unsup;
  logic [31:0]       wdata_acc, load_data;
  logic [3:0]        be_acc;

  // Decode the incoming request: alignment/fault policy, store lanes and byte enables.
  always_comb begin
    f3_acc   = req_funct3;
    addr_acc = req_addr;
    mis_acc  = 1'b0;
    unsup    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    mis_acc = unsup || ((req_funct3[1:0] == 2'b01) && req_addr[0])
                    || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    if (unsup) f3_acc = 3'b010;
    if (f3_acc[1:0] == 2'b01) addr_acc[0] = 1'b0;
    else if (f3_acc[1:0] == 2'b10) addr_acc[1:0] = 2'b00;
`endif
    case (f3_acc[1:0])
      2'b00: begin
        wdata_acc = {4{req_wdata[7:0]}};
        be_acc    = 4'b0001 << addr_acc[1:0];
      end
      2'b01: begin
        wdata_acc = {2{req_wdata[15:0]}};
        be_acc    = 4'b0011 << addr_acc[1:0];
      end
      default: begin
        wdata_acc = req_wdata;
        be_acc    = 4'b1111;
      end
    endcase
  end

  // Word offset k lives on data_read[31-8k:24-8k]; assemble little-endian values from that.
  always_comb begin
    logic [7:0]  b0, b1, b2, b3, bsel;
    logic [15:0] hsel;
    b0 = data_read[31:24];
    b1 = data_read[23:16];
    b2 = data_read[15:8];
    b3 = data_read[7:0];
    case (addr_q[1:0])
      2'b00:   bsel = b0;
      2'b01:   bsel = b1;
      2'b10:   bsel = b2;
      default: bsel = b3;
    endcase
    hsel = addr_q[1] ? {b3, b2} : {b1, b0};
    case (f3_q[1:0])
      2'b00:   load_data = {{24{~f3_q[2] & bsel[7]}}, bsel};
      2'b01:   load_data = {{16{~f3_q[2] & hsel[15]}}, hsel};
      default: load_data = {b3, b2, b1, b0};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      f3_q         <= '0;
      store_q      <= 1'b0;
      rd_q         <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_mis_q   <= 1'b0;
      resp_rdata_q <= '0;
      resp_rd_q    <= '0;
      rvalid_q     <= 1'b0;
      wvalid_q     <= 1'b0;
      data_addr_q  <= '0;
      data_write_q <= '0;
      data_be_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready_q) begin
            addr_q      <= addr_acc;
            f3_q        <= f3_acc;
            store_q     <= req_is_store;
            rd_q        <= req_rd;
            req_ready_q <= 1'b0;
            if (mis_acc) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              resp_mis_q   <= 1'b1;
              resp_rdata_q <= '0;
              resp_rd_q    <= req_rd;
            end else begin
              state_q     <= StMem;
              data_addr_q <= addr_acc;
              if (req_is_store) begin
                wvalid_q     <= 1'b1;
                data_write_q <= wdata_acc;
                data_be_q    <= be_acc;
              end else begin
                rvalid_q  <= 1'b1;
                data_be_q <= '0;
                cnt_q     <= 4'(READ_LAT - 1);
              end
            end
          end
        end
        StMem: begin
          if (store_q || (cnt_q == '0)) begin
            state_q      <= StResp;
            wvalid_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            data_addr_q  <= '0;
            data_write_q <= '0;
            data_be_q    <= '0;
            resp_valid_q <= 1'b1;
            resp_mis_q   <= 1'b0;
            resp_rd_q    <= rd_q;
            resp_rdata_q <= store_q ? 32'h0 : load_data;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            state_q      <= StIdle;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_mis_q   <= 1'b0;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = resp_rdata_q;
  assign resp_rd          = resp_rd_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign resp_misaligned  = resp_mis_q;
`else
  assign resp_misaligned  = 1'b0;
`endif
  assign data_addr        = data_addr_q;
  assign data_write       = data_write_q;
  assign data_write_byte  = data_be_q;
  assign data_read_valid  = rvalid_q;
  assign data_write_valid = wvalid_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed self-checking bench for lsu_mem_if (READ_LAT=1 main instance, READ_LAT=3 reset instance).
module tb_lsu_mem_if;

  logic        clk = 1'b0;
  logic        rst_n, rst3_n;
  logic        req_valid, req_is_store, resp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, data_read;
  logic [4:0]  req_rd;

  logic        req_ready, resp_valid, resp_mis, rvalid, wvalid;
  logic [31:0] resp_rdata, data_addr, data_write;
  logic [4:0]  resp_rd;
  logic [3:0]  data_be;

  logic        req_ready3, resp_valid3, resp_mis3, rvalid3, wvalid3;
  logic [31:0] resp_rdata3, data_addr3, data_write3;
  logic [4:0]  resp_rd3;
  logic [3:0]  data_be3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu_mem_if #(.READ_LAT(1), .ADDR_W(32)) u_dut (
    .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_misaligned(resp_mis),
    .data_addr(data_addr), .data_write(data_write), .data_write_byte(data_be),
    .data_read_valid(rvalid), .data_write_valid(wvalid), .data_read(data_read)
  );

  lsu_mem_if #(.READ_LAT(3), .ADDR_W(32)) u_dut3 (
    .clk(clk), .reset(rst3_n), .req_valid(req_valid), .req_ready(req_ready3),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(resp_valid3), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata3), .resp_rd(resp_rd3), .resp_misaligned(resp_mis3),
    .data_addr(data_addr3), .data_write(data_write3), .data_write_byte(data_be3),
    .data_read_valid(rvalid3), .data_write_valid(wvalid3), .data_read(data_read)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single accepting edge, then drop req_valid.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_rd = rd;
    step();
    req_valid = 1'b0;
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be, input logic [31:0] wexp);
    do_req(1'b1, f3, a, wd, 5'd3);
    check({tag, " wvalid"}, 32'(wvalid), 32'd1);
    check({tag, " rvalid"}, 32'(rvalid), 32'd0);
    check({tag, " addr"}, data_addr, a);
    check({tag, " be"}, 32'(data_be), 32'(be));
    check({tag, " wdata"}, data_write, wexp);
    step();
    check({tag, " wvalid drop"}, 32'(wvalid), 32'd0);
    check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, " resp_rdata"}, resp_rdata, 32'd0);
    step();
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp);
    do_req(1'b0, f3, a, 32'h0, 5'd7);
    check({tag, " rvalid"}, 32'(rvalid), 32'd1);
    check({tag, " be"}, 32'(data_be), 32'd0);
    step();
    check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, " rdata"}, resp_rdata, exp);
    check({tag, " rd"}, 32'(resp_rd), 32'd7);
    check({tag, " mis"}, 32'(resp_mis), 32'd0);
    step();
  endtask

  initial begin
    rst_n = 1'b0; rst3_n = 1'b0;
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    resp_ready = 1'b1; data_read = 32'h11803344;
    step();
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst rvalid", 32'(rvalid), 32'd0);
    check("rst wvalid", 32'(wvalid), 32'd0);
    check("rst data_addr", data_addr, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    run_store("sw", 3'b010, 32'h8, 32'h12345678, 4'b1111, 32'h12345678);
    run_store("sb", 3'b000, 32'h5, 32'h000000AB, 4'b0010, 32'hABABABAB);
    run_store("sh", 3'b001, 32'h6, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF);

    run_load("lb", 3'b000, 32'h1, 32'hFFFFFF80);
    run_load("lbu", 3'b100, 32'h1, 32'h00000080);
    run_load("lh", 3'b001, 32'h2, 32'h00004433);
    run_load("lw", 3'b010, 32'h0, 32'h44338011);
    run_load("lhu", 3'b101, 32'h0, 32'h00008011);

`ifdef LSU_MISALIGN_TRAP_EN
    do_req(1'b0, 3'b010, 32'h6, 32'h0, 5'd9);
    check("mis resp_valid", 32'(resp_valid), 32'd1);
    check("mis flag", 32'(resp_mis), 32'd1);
    check("mis rvalid", 32'(rvalid), 32'd0);
    check("mis wvalid", 32'(wvalid), 32'd0);
    check("mis rd", 32'(resp_rd), 32'd9);
    step();
`else
    do_req(1'b0, 3'b010, 32'h6, 32'h0, 5'd9);
    check("align rvalid", 32'(rvalid), 32'd1);
    check("align addr", data_addr, 32'h4);
    step();
    check("align resp_valid", 32'(resp_valid), 32'd1);
    check("align mis", 32'(resp_mis), 32'd0);
    check("align rdata", resp_rdata, 32'h44338011);
    step();
`endif

    // Backpressure: response held while a competing request is presented.
    resp_ready = 1'b0;
    do_req(1'b0, 3'b100, 32'h1, 32'h0, 5'd12);
    step();
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'hDEADBEEF; req_rd = 5'd1;
    for (int i = 0; i < 5; i++) begin
      check("bp resp_valid", 32'(resp_valid), 32'd1);
      check("bp rdata", resp_rdata, 32'h00000080);
      check("bp rd", 32'(resp_rd), 32'd12);
      check("bp req_ready", 32'(req_ready), 32'd0);
      check("bp wvalid", 32'(wvalid), 32'd0);
      step();
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    check("bp release resp_valid", 32'(resp_valid), 32'd0);
    check("bp release req_ready", 32'(req_ready), 32'd1);
    check("bp release wvalid", 32'(wvalid), 32'd0);
    step();

    // READ_LAT=3 instance: reset during the second MEM cycle abandons the load.
    rst3_n = 1'b1;
    step();
    check("r3 req_ready", 32'(req_ready3), 32'd1);
    do_req(1'b0, 3'b010, 32'h0, 32'h0, 5'd4);
    check("r3 mem1 rvalid", 32'(rvalid3), 32'd1);
    step();
    check("r3 mem2 rvalid", 32'(rvalid3), 32'd1);
    check("r3 mem2 addr", data_addr3, 32'h0);
    rst3_n = 1'b0;
    #1;
    check("r3 rst rvalid", 32'(rvalid3), 32'd0);
    check("r3 rst req_ready", 32'(req_ready3), 32'd1);
    check("r3 rst resp_valid", 32'(resp_valid3), 32'd0);
    step();
    rst3_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (resp_valid3 || rvalid3) seen++;
      end
      check("r3 no response", 32'(seen), 32'd0);
    end
    check("r3 idle req_ready", 32'(req_ready3), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
